// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns in {g,f,e,d,c,b,a} order, segment bit positions, dead-time counter width.
package sseg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Wide enough for the full 0-15 dead-time range.
    localparam int DEAD_W = 4;

endpackage

// File: rtl/sseg_decoder.sv
// Combinational BCD-to-seven-segment decoder, active-low outputs.
// Non-decimal codes (10-15) render as a dash so bad data is visible.
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_display_driver.sv
// Multiplexed seven-segment driver: snapshots BCD on load, follows the one-cold
// digit ring with anti-ghost blanking. Optional feature: SSEG_LEADING_ZERO_BLANK_EN.
module sseg_display_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEADTIME = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     ring,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DEAD_W-1:0] DEAD_INIT = DEAD_W'(DEADTIME);

    logic [4*DIGITS-1:0] digit_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   ring_q;
    logic [DEAD_W-1:0]   dead_cnt;

    logic                ring_valid;
    logic [IDX_W-1:0]    sel_idx;
    logic [3:0]          sel_digit;
    logic [6:0]          sel_seg_dec;
    logic [6:0]          sel_seg;
    logic                sel_dp;
    int                  zero_cnt;

    // Locate the single zero in ring_q; any other zero count is an invalid pattern.
    always_comb begin
        zero_cnt = 0;
        sel_idx  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!ring_q[i]) begin
                zero_cnt = zero_cnt + 1;
                sel_idx  = IDX_W'(i);
            end
        end
        ring_valid = (zero_cnt == 1);
    end

    assign sel_digit = digit_q[4*int'(sel_idx) +: 4];
    assign sel_dp    = dp_q[sel_idx];

    sseg_decoder u_decoder (
        .digit (sel_digit),
        .seg   (sel_seg_dec)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_d;
    logic [DIGITS-1:0] blank_q;
    logic              zero_run;

    // A digit blanks only if it and every more significant digit are zero.
    always_comb begin
        blank_d  = '0;
        zero_run = 1'b1;
        for (int i = DIGITS-1; i > 0; i--) begin
            zero_run   = zero_run & (bcd[4*i +: 4] == 4'd0);
            blank_d[i] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else if (load) begin
            blank_q <= blank_d;
        end
    end

    assign sel_seg = blank_q[sel_idx] ? SEG_BLANK : sel_seg_dec;
`else
    assign sel_seg = sel_seg_dec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            digit_q <= bcd;
            dp_q    <= dp_in;
        end
    end

    // Any ring change restarts the dead-time; drive only once it has expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q   <= '1;
            dead_cnt <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else if (ring != ring_q) begin
            ring_q   <= ring;
            dead_cnt <= DEAD_INIT;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - 1'b1;
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end else if (ring_valid) begin
            an       <= ring_q;
            seg      <= sel_seg;
            dp       <= ~sel_dp;
        end else begin
            an       <= '1;
            seg      <= SEG_BLANK;
            dp       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sseg_display_driver.sv
// Directed bench for sseg_display_driver (DIGITS=4, DEADTIME=2); expectations
// follow SSEG_LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_sseg_display_driver;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SOFF  = 7'b1111111;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SLZ   = SOFF;
`else
    localparam logic [6:0] SLZ   = S0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ring;
    logic        load;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;

    sseg_display_driver #(.DIGITS(4), .DEADTIME(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .ring  (ring),
        .load  (load),
        .bcd   (bcd),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dp_e);
        chk({tag, "_an"},  32'(an),  32'(an_e));
        chk({tag, "_seg"}, 32'(seg), 32'(seg_e));
        chk({tag, "_dp"},  32'(dp),  32'(dp_e));
    endtask

    // Three blank edges starting with the change edge, then the digit.
    task automatic blank_then_show(input string tag, input logic [3:0] an_e,
                                   input logic [6:0] seg_e, input logic dp_e);
        for (int k = 0; k < 3; k++) begin
            tick();
            load = 1'b0;
            chk_out({tag, "_blank"}, 4'hF, SOFF, 1'b1);
        end
        tick();
        chk_out(tag, an_e, seg_e, dp_e);
    endtask

    task automatic hold(input string tag, input int n, input logic [3:0] an_e,
                        input logic [6:0] seg_e, input logic dp_e);
        for (int k = 0; k < n; k++) begin
            tick();
            chk_out(tag, an_e, seg_e, dp_e);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ring  = 4'hF;
        load  = 1'b0;
        bcd   = 16'h0000;
        dp_in = 4'h0;
        #1;
        chk_out("reset", 4'hF, SOFF, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_out("idle_invalid", 4'hF, SOFF, 1'b1);

        // Load together with the first ring change.
        ring  = 4'b1110;
        load  = 1'b1;
        bcd   = 16'h1234;
        dp_in = 4'h0;
        blank_then_show("first_d0", 4'b1110, S4, 1'b1);
        hold("hold_d0", 4, 4'b1110, S4, 1'b1);

        ring = 4'b1101;
        blank_then_show("rot_d1", 4'b1101, S3, 1'b1);
        hold("hold_d1", 4, 4'b1101, S3, 1'b1);
        ring = 4'b1011;
        blank_then_show("rot_d2", 4'b1011, S2, 1'b1);
        hold("hold_d2", 4, 4'b1011, S2, 1'b1);
        ring = 4'b0111;
        blank_then_show("rot_d3", 4'b0111, S1, 1'b1);
        hold("hold_d3", 4, 4'b0111, S1, 1'b1);

        ring = 4'b1100;
        hold("two_zero", 6, 4'hF, SOFF, 1'b1);
        ring = 4'b1111;
        hold("no_zero", 5, 4'hF, SOFF, 1'b1);
        ring = 4'b1110;
        blank_then_show("recover_d0", 4'b1110, S4, 1'b1);

        // Mid-display load shows on the edge after the snapshot edge.
        load  = 1'b1;
        bcd   = 16'h00A7;
        dp_in = 4'b0001;
        tick();
        load = 1'b0;
        chk_out("load_edge", 4'b1110, S4, 1'b1);
        tick();
        chk_out("load_next", 4'b1110, S7, 1'b0);
        ring = 4'b1101;
        blank_then_show("dash_d1", 4'b1101, SDASH, 1'b1);
        ring = 4'b1011;
        blank_then_show("lz_d2", 4'b1011, SLZ, 1'b1);
        ring = 4'b0111;
        blank_then_show("lz_d3", 4'b0111, SLZ, 1'b1);

        // Ring change during dead-time restarts the countdown.
        ring = 4'b1110;
        tick();
        chk_out("restart_first", 4'hF, SOFF, 1'b1);
        ring = 4'b1101;
        blank_then_show("restart_d1", 4'b1101, SDASH, 1'b1);

        load  = 1'b1;
        bcd   = 16'h0005;
        dp_in = 4'h0;
        tick();
        load = 1'b0;
        tick();
        chk_out("b0005_d1", 4'b1101, SLZ, 1'b1);
        ring = 4'b1110;
        blank_then_show("b0005_d0", 4'b1110, S5, 1'b1);
        load = 1'b1;
        bcd  = 16'h0000;
        tick();
        load = 1'b0;
        tick();
        chk_out("b0000_d0", 4'b1110, S0, 1'b1);
        ring = 4'b1011;
        blank_then_show("b0000_d2", 4'b1011, SLZ, 1'b1);

        // Asynchronous reset mid-display, then resume on the held ring.
        load  = 1'b1;
        bcd   = 16'h0800;
        tick();
        load = 1'b0;
        tick();
        chk_out("pre_rst", 4'b1011, S0 ^ 7'b1000000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 4'hF, SOFF, 1'b1);
        tick();
        rst = 1'b0;
        blank_then_show("post_rst", 4'b1011, S0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_display_driver.md
# sseg_display_driver

Multiplexed seven-segment display driver for the stopwatch display path. It sits directly downstream of the digit-select ring counter and consumes its one-cold rotating pattern to choose the active digit. It snapshots a packed BCD word on a load strobe and drives active-low anodes, segments and decimal point. An anti-ghosting dead-time blanks the display for a programmable number of cycles after every anode change.

## Interface
Parameters:
- DIGITS, 4: number of display digits; also the ring width. Must be ≥ 2.
- DEADTIME, 2: extra blanking cycles after each ring change. Range 0–15.

Ports:
- clk  input  1  system clock, posedge.
- rst  input  1  reset, asynchronous, active-high.
- ring  input  DIGITS  digit select from the ring counter. Exactly one bit is 0; that bit's index is the active digit.
- load  input  1  single-cycle strobe to snapshot bcd and dp_in.
- bcd  input  4*DIGITS  packed digits. Digit i is bcd[4i+3:4i]; digit DIGITS-1 is the most significant.
- dp_in  input  DIGITS  decimal point request per digit, active-high.
- an  output  DIGITS  anodes, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- Snapshot: on load=1, bcd and dp_in are registered into internal digit and dp registers. Otherwise the registers hold.
- Ring tracking: ring is compared to the registered copy ring_q on every edge.
  - On mismatch: ring_q <= ring, dead counter <= DEADTIME, and an/seg/dp are driven all ones.
  - While the counter is nonzero: it decrements, and the outputs stay all ones.
- Drive: when the counter is 0 and ring_q is valid (exactly one zero), the outputs are registered as:
  - an <= ring_q;
  - seg <= decode of the digit selected by the zero bit of ring_q;
  - dp <= ~dp of that digit.
- Invalid ring_q (no zero, or more than one zero): an, seg and dp are held all ones for as long as the pattern stays invalid.
- Decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10–15 display a dash, 0111111.
- Outputs are decoded every cycle in the drive state, so a load takes effect on the next edge without waiting for a ring change.

## Timing
- Reset values:
  - an, seg and dp are all ones.
  - ring_q is all ones (invalid), the dead counter is 0, and the digit and dp registers are 0.
- Ring change sampled at edge E0: outputs are blank from E0 through edge E_DEADTIME. The new digit is driven at E_(DEADTIME+1).
  - Blank window is DEADTIME+1 cycles. DEADTIME=0 gives a 1-cycle blank.
- Load at edge E: the snapshot updates at E, and seg/dp reflect the new value at E+1 if in the drive state.
- Load and ring change on the same edge: both take effect. The new digit value is shown once the dead-time ends.
- Ring change during the dead-time: the counter restarts at DEADTIME.
- Reset mid-operation: outputs go all ones asynchronously. The first valid ring after reset counts as a change and is blanked for DEADTIME+1 cycles.
- Combinational path from inputs to outputs: none. All outputs are registered.

## Configuration
- SSEG_LEADING_ZERO_BLANK_EN defined:
  - Digit i (i>0) is blanked (seg=1111111) when it and all higher digits in the snapshot equal 0.
  - Digit 0 is never blanked.
  - dp is unaffected.
  - The blank mask is computed at snapshot time and registered with the snapshot.
- Macro undefined: all digits always decode normally, and no mask logic is built.

## Structure
- Package sseg_pkg holds:
  - the segment constants SEG_0…SEG_9, SEG_DASH and SEG_BLANK;
  - the segment bit-order constants;
  - the DEADTIME counter width.
- Sub-module sseg_decoder: purely combinational, 4-bit digit to 7-bit active-low segments. Instantiated once on the muxed digit.
- The top level holds the snapshot registers, ring_q, the validity check, the dead counter and the output registers.

## Test plan
- Reset, then ring=1110, load with bcd=16'h1234 → after 3 blank cycles, an=1110, seg=0011001 ("4"), dp=1.
- Ring rotating 1110→1101→1011→0111, one step per 8 cycles, DEADTIME=2 → each step gives exactly 3 cycles of an=1111, then the digits "3", "2", "1" are shown in turn.
- ring=1100, then ring=1111 → an=1111 and seg=1111111 for as long as the pattern persists. Returning to 1110 gives 3 blank cycles, then "4".
- Mid-display load of bcd=16'h00A7 with dp_in=0001 while showing digit 0 → next cycle seg=1111000, dp=0. On digit 1, seg=0111111 (dash).
- With SSEG_LEADING_ZERO_BLANK_EN, bcd=16'h0005 → digits 3–1 seg=1111111, digit 0 seg=0010010. bcd=16'h0000 → digit 0 shows "0".
- Assert rst while an=1011 → outputs all ones immediately. After release with ring=1011, the display resumes after DEADTIME+1 cycles showing "0".
